// File: rtl/fastram_bus_frontend_if.sv
// CPU-side and controller-side signals of the fast-RAM front end, grouped so the
// front end (slave) and its environment (master) connect through a single port.
interface fastram_bus_frontend_if;
  logic        AS_N;
  logic        UDS_N;
  logic        LDS_N;
  logic        RW;
  logic [23:1] A;
  logic        VALID;
  logic        WTERM;
  logic [15:0] DQ_IN;
  logic        ACCESS;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        DTACK_N;
  logic        BERR_N;
  // Synchronised byte strobes, handed on so the controller can consume them
  logic        UDS_S_N;
  logic        LDS_S_N;

  modport slave (
    input  AS_N, UDS_N, LDS_N, RW, A, VALID, WTERM, DQ_IN,
    output ACCESS, D_OUT, D_OE, DTACK_N, BERR_N, UDS_S_N, LDS_S_N
  );

  modport master (
    output AS_N, UDS_N, LDS_N, RW, A, VALID, WTERM, DQ_IN,
    input  ACCESS, D_OUT, D_OE, DTACK_N, BERR_N, UDS_S_N, LDS_S_N
  );
endinterface

// File: rtl/fastram_bus_frontend.sv
// 68000 front end for the SDRAM fast-RAM controller: window decode, ACCESS request,
// DTACK_N generation and read-data latching. Define FRONTEND_BERR_EN for the BERR_N watchdog.
module fastram_bus_frontend #(
  parameter logic [2:0] WIN_BASE = 3'b001,
  parameter logic [7:0] TIMEOUT  = 8'd200
) (
  input logic                   CLK,
  input logic                   RST,
  fastram_bus_frontend_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_ACK,
    S_END
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  as_sync_q, uds_sync_q, lds_sync_q, rw_sync_q;
  logic        s_as, s_rw, hit;
  logic        access_q, access_d;
  logic        dtack_q, dtack_d;
  logic        doe_q, doe_d;
  logic [15:0] dout_q, dout_d;
`ifdef FRONTEND_BERR_EN
  logic        berr_q, berr_d;
  logic [7:0]  wdog_q, wdog_d;
`endif

  assign s_as = as_sync_q[1];
  assign s_rw = rw_sync_q[1];
  // A is only looked at once sAS is low, by which time the CPU holds it stable
  assign hit  = !s_as && (bus.A[23:21] == WIN_BASE);

  // ---- stage: strobe synchronisers, preset to the inactive level ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      as_sync_q  <= 2'b11;
      uds_sync_q <= 2'b11;
      lds_sync_q <= 2'b11;
      rw_sync_q  <= 2'b11;
    end else begin
      as_sync_q  <= {as_sync_q[0],  bus.AS_N};
      uds_sync_q <= {uds_sync_q[0], bus.UDS_N};
      lds_sync_q <= {lds_sync_q[0], bus.LDS_N};
      rw_sync_q  <= {rw_sync_q[0],  bus.RW};
    end
  end

  // ---- stage: bus-cycle FSM and registered outputs ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      access_q <= 1'b1;
      dtack_q  <= 1'b1;
      doe_q    <= 1'b0;
      dout_q   <= 16'h0000;
`ifdef FRONTEND_BERR_EN
      berr_q   <= 1'b1;
      wdog_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      dtack_q  <= dtack_d;
      doe_q    <= doe_d;
      dout_q   <= dout_d;
`ifdef FRONTEND_BERR_EN
      berr_q   <= berr_d;
      wdog_q   <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    dtack_d  = dtack_q;
    doe_d    = doe_q;
    dout_d   = dout_q;
`ifdef FRONTEND_BERR_EN
    berr_d   = berr_q;
    wdog_d   = 8'd0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          access_d = 1'b0;
          state_d  = s_rw ? S_RD_WAIT : S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        // An abandoned cycle wins over a simultaneous VALID; D_OUT keeps its old word
        if (s_as) begin
          state_d = S_END;
        end else if (!bus.VALID) begin
          dout_d  = bus.DQ_IN;
          doe_d   = 1'b1;
          dtack_d = 1'b1;
          state_d = S_ACK;
        end
`ifdef FRONTEND_BERR_EN
        else if (wdog_q == TIMEOUT - 8'd1) begin
          berr_d  = 1'b0;
          state_d = S_ACK;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
`endif
      end
      S_WR_WAIT: begin
        // Writes need no data setup, so DTACK_N drops on the same edge as WTERM is seen
        if (s_as) begin
          state_d = S_END;
        end else if (!bus.WTERM) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end
`ifdef FRONTEND_BERR_EN
        else if (wdog_q == TIMEOUT - 8'd1) begin
          berr_d  = 1'b0;
          state_d = S_ACK;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
`endif
      end
      S_ACK: begin
`ifdef FRONTEND_BERR_EN
        dtack_d = berr_q ? 1'b0 : 1'b1;
`else
        dtack_d = 1'b0;
`endif
        if (s_as) state_d = S_END;
      end
      S_END: begin
        access_d = 1'b1;
        dtack_d  = 1'b1;
        doe_d    = 1'b0;
`ifdef FRONTEND_BERR_EN
        berr_d   = 1'b1;
`endif
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ACCESS  = access_q;
  assign bus.DTACK_N = dtack_q;
  assign bus.D_OE    = doe_q;
  assign bus.D_OUT   = dout_q;
  assign bus.UDS_S_N = uds_sync_q[1];
  assign bus.LDS_S_N = lds_sync_q[1];
`ifdef FRONTEND_BERR_EN
  assign bus.BERR_N  = berr_q;
`else
  assign bus.BERR_N  = 1'b1;
`endif

endmodule
